// File: rtl/cr_had_dbgreq_ctrl_if.sv
// HAD debug-request controller signal bundle.
// The slave side is the controller; the master side is the core/regs side.
interface cr_had_dbgreq_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             bkpt_ctrl_req;
  logic             bkpt_ctrl_inst_fetch_dbq_req;
  logic             iu_had_flush;
  logic             iu_had_xx_retire_normal;
  logic             iu_yy_xx_dbgon;
  logic             regs_ctrl_halt_req;
  logic             regs_ctrl_step_en;
  logic             regs_ctrl_exit_dbg;
  logic             regs_ctrl_cause_clr;
  logic             had_core_dbg_mode_req;
  logic             had_core_exit_dbg;
  logic [2:0]       ctrl_regs_dbg_cause;
  logic             ctrl_regs_req_timeout;
  logic [CNT_W-1:0] ctrl_regs_bkpt_cnt;

  modport slave (
    input  bkpt_ctrl_req,
    input  bkpt_ctrl_inst_fetch_dbq_req,
    input  iu_had_flush,
    input  iu_had_xx_retire_normal,
    input  iu_yy_xx_dbgon,
    input  regs_ctrl_halt_req,
    input  regs_ctrl_step_en,
    input  regs_ctrl_exit_dbg,
    input  regs_ctrl_cause_clr,
    output had_core_dbg_mode_req,
    output had_core_exit_dbg,
    output ctrl_regs_dbg_cause,
    output ctrl_regs_req_timeout,
    output ctrl_regs_bkpt_cnt
  );

  modport master (
    output bkpt_ctrl_req,
    output bkpt_ctrl_inst_fetch_dbq_req,
    output iu_had_flush,
    output iu_had_xx_retire_normal,
    output iu_yy_xx_dbgon,
    output regs_ctrl_halt_req,
    output regs_ctrl_step_en,
    output regs_ctrl_exit_dbg,
    output regs_ctrl_cause_clr,
    input  had_core_dbg_mode_req,
    input  had_core_exit_dbg,
    input  ctrl_regs_dbg_cause,
    input  ctrl_regs_req_timeout,
    input  ctrl_regs_bkpt_cnt
  );
endinterface

// File: rtl/cr_had_dbgreq_ctrl.sv
// HAD debug-entry controller: arbitrates halt/bkpt/step sources,
// requests debug mode, records cause, counts bkpt entries, sequences exit.
module cr_had_dbgreq_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TMR_W       = 8,
  parameter int CNT_W       = 8
) (
  input logic                 cpuclk,
  input logic                 hadrst,
  cr_had_dbgreq_ctrl_if.slave io
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DBG  = 2'd2,
    EXIT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             inst_pend_q, inst_pend_d;
  logic             step_pend_q, step_pend_d;
  logic             req_q, req_d;
  logic             exit_q, exit_d;

  logic             inst_src;
  logic             step_src;
  logic             any_src;
  logic [2:0]       src_cause;
  logic             go_req;
  logic             step_set;
  logic [CNT_W-1:0] cnt_base;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    go_req    = 1'b0;
    step_set  = 1'b0;
    cnt_base  = cnt_q;
    inst_src  = inst_pend_q & ~io.iu_had_flush;
    step_src  = step_pend_q & io.iu_had_xx_retire_normal;
    any_src   = io.regs_ctrl_halt_req | io.bkpt_ctrl_req
              | inst_src | step_src;
    src_cause = 3'd0;
    if (io.regs_ctrl_halt_req)  src_cause = 3'd1;
    else if (io.bkpt_ctrl_req)  src_cause = 3'd2;
    else if (inst_src)          src_cause = 3'd3;
    else if (step_src)          src_cause = 3'd4;

    // Clear first so a same-cycle capture/increment overrides it.
    if (io.regs_ctrl_cause_clr) begin
      cause_d  = 3'd0;
      cnt_d    = '0;
      cnt_base = '0;
      to_d     = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (io.iu_yy_xx_dbgon) begin
          state_d = DBG;
        end else if (any_src) begin
          state_d = REQ;
          timer_d = '0;
          cause_d = src_cause;
          go_req  = 1'b1;
        end
      end
      REQ: begin
        if (io.iu_yy_xx_dbgon) begin
          state_d = DBG;
          if (cause_q == 3'd2 || cause_q == 3'd3) begin
            if (cnt_base != {CNT_W{1'b1}})
              cnt_d = cnt_base + 1'b1;
            else
              cnt_d = cnt_base;
          end
        end else if (timer_q == TMR_W'(TIMEOUT_CYC)) begin
          state_d = IDLE;
          to_d    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DBG: begin
        if (io.regs_ctrl_exit_dbg) state_d = EXIT;
      end
      EXIT: begin
        if (!io.iu_yy_xx_dbgon) begin
          state_d  = IDLE;
          step_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    inst_pend_d = inst_pend_q;
    if (io.iu_had_flush || go_req)
      inst_pend_d = 1'b0;
    else if (state_q == IDLE && io.bkpt_ctrl_inst_fetch_dbq_req)
      inst_pend_d = 1'b1;

    step_pend_d = step_pend_q;
    if (!io.regs_ctrl_step_en || go_req)
      step_pend_d = 1'b0;
    else if (step_set)
      step_pend_d = 1'b1;

    req_d  = (state_d == REQ);
    exit_d = (state_d == EXIT);
  end

  always_ff @(posedge cpuclk) begin
    if (hadrst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      cause_q     <= 3'd0;
      cnt_q       <= '0;
      to_q        <= 1'b0;
      inst_pend_q <= 1'b0;
      step_pend_q <= 1'b0;
      req_q       <= 1'b0;
      exit_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
      to_q        <= to_d;
      inst_pend_q <= inst_pend_d;
      step_pend_q <= step_pend_d;
      req_q       <= req_d;
      exit_q      <= exit_d;
    end
  end

  assign io.had_core_dbg_mode_req = req_q;
  assign io.had_core_exit_dbg     = exit_q;
  assign io.ctrl_regs_dbg_cause   = cause_q;
  assign io.ctrl_regs_req_timeout = to_q;
  assign io.ctrl_regs_bkpt_cnt    = cnt_q;
endmodule

// File: tb/tb_cr_had_dbgreq_ctrl.sv
// Scoreboard bench for cr_had_dbgreq_ctrl (TIMEOUT_CYC=4, CNT_W=2).
// Expected output vectors {req,exit,cause,timeout,cnt} are queued per cycle.
module tb_cr_had_dbgreq_ctrl;
  logic clk;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;

  typedef struct {
    string      nm;
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];

  cr_had_dbgreq_ctrl_if #(.CNT_W(2)) io();

  cr_had_dbgreq_ctrl #(
    .TIMEOUT_CYC(4),
    .TMR_W(8),
    .CNT_W(2)
  ) dut (
    .cpuclk(clk),
    .hadrst(rst),
    .io(io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares DUT outputs against queued expectations.
  always @(negedge clk) begin
    logic [7:0] act;
    exp_t e;
    act = {io.had_core_dbg_mode_req, io.had_core_exit_dbg,
           io.ctrl_regs_dbg_cause, io.ctrl_regs_req_timeout,
           io.ctrl_regs_bkpt_cnt};
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_vec++;
      if (e.cyc != cyc) begin
        n_err++;
        $display("FAIL %s: missed check cycle %0d (now %0d)",
                 e.nm, e.cyc, cyc);
      end else if (act !== e.val) begin
        n_err++;
        $display("FAIL %s: got req=%b exit=%b cause=%0d to=%b cnt=%0d, want req=%b exit=%b cause=%0d to=%b cnt=%0d",
                 e.nm, act[7], act[6], act[5:3], act[2], act[1:0],
                 e.val[7], e.val[6], e.val[5:3], e.val[2], e.val[1:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic r, input logic e,
                     input logic [2:0] c, input logic t,
                     input logic [1:0] n);
    exp_t x;
    x.nm  = nm;
    x.cyc = cyc;
    x.val = {r, e, c, t, n};
    sb_q.push_back(x);
  endtask

  task automatic do_exit(input string nm, input logic [2:0] c,
                         input logic [1:0] n);
    io.regs_ctrl_exit_dbg = 1'b1;
    tick();
    io.regs_ctrl_exit_dbg = 1'b0;
    chk({nm, "_exit"}, 1'b0, 1'b1, c, 1'b0, n);
    io.iu_yy_xx_dbgon = 1'b0;
    tick();
    chk({nm, "_idle"}, 1'b0, 1'b0, c, 1'b0, n);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    io.bkpt_ctrl_req = 1'b0;
    io.bkpt_ctrl_inst_fetch_dbq_req = 1'b0;
    io.iu_had_flush = 1'b0;
    io.iu_had_xx_retire_normal = 1'b0;
    io.iu_yy_xx_dbgon = 1'b0;
    io.regs_ctrl_halt_req = 1'b0;
    io.regs_ctrl_step_en = 1'b0;
    io.regs_ctrl_exit_dbg = 1'b0;
    io.regs_ctrl_cause_clr = 1'b0;
    tick();
    chk("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk("idle0", 0, 0, 0, 0, 0);

    // Data bkpt, core acks on the third request cycle.
    io.bkpt_ctrl_req = 1'b1;
    tick();
    io.bkpt_ctrl_req = 1'b0;
    chk("t1_req1", 1, 0, 2, 0, 0);
    tick();
    chk("t1_req2", 1, 0, 2, 0, 0);
    tick();
    chk("t1_req3", 1, 0, 2, 0, 0);
    io.iu_yy_xx_dbgon = 1'b1;
    tick();
    chk("t1_dbg", 0, 0, 2, 0, 1);
    io.regs_ctrl_halt_req = 1'b1;
    io.bkpt_ctrl_req = 1'b1;
    tick();
    io.regs_ctrl_halt_req = 1'b0;
    io.bkpt_ctrl_req = 1'b0;
    chk("t1_dbg_ign", 0, 0, 2, 0, 1);
    io.bkpt_ctrl_inst_fetch_dbq_req = 1'b1;
    tick();
    io.bkpt_ctrl_inst_fetch_dbq_req = 1'b0;
    chk("t1_dbg_ifb", 0, 0, 2, 0, 1);
    io.regs_ctrl_exit_dbg = 1'b1;
    tick();
    io.regs_ctrl_exit_dbg = 1'b0;
    chk("t1_exit", 0, 1, 2, 0, 1);
    tick();
    chk("t1_exit_hold", 0, 1, 2, 0, 1);
    io.iu_yy_xx_dbgon = 1'b0;
    tick();
    chk("t1_idle", 0, 0, 2, 0, 1);
    tick();
    chk("t1_no_pend", 0, 0, 2, 0, 1);

    // All three sources together: halt wins, inst_pend dropped.
    io.regs_ctrl_halt_req = 1'b1;
    io.bkpt_ctrl_req = 1'b1;
    io.bkpt_ctrl_inst_fetch_dbq_req = 1'b1;
    tick();
    io.regs_ctrl_halt_req = 1'b0;
    io.bkpt_ctrl_req = 1'b0;
    io.bkpt_ctrl_inst_fetch_dbq_req = 1'b0;
    chk("t2_req", 1, 0, 1, 0, 1);
    io.iu_yy_xx_dbgon = 1'b1;
    tick();
    chk("t2_dbg", 0, 0, 1, 0, 1);
    do_exit("t2", 1, 1);
    tick();
    chk("t2_no_pend", 0, 0, 1, 0, 1);

    // Inst-fetch bkpt squashed by flush, then unsquashed.
    io.bkpt_ctrl_inst_fetch_dbq_req = 1'b1;
    tick();
    io.bkpt_ctrl_inst_fetch_dbq_req = 1'b0;
    chk("t3_pend", 0, 0, 1, 0, 1);
    io.iu_had_flush = 1'b1;
    tick();
    io.iu_had_flush = 1'b0;
    chk("t3_flush", 0, 0, 1, 0, 1);
    tick();
    chk("t3_flush2", 0, 0, 1, 0, 1);
    io.bkpt_ctrl_inst_fetch_dbq_req = 1'b1;
    tick();
    io.bkpt_ctrl_inst_fetch_dbq_req = 1'b0;
    chk("t3_pend2", 0, 0, 1, 0, 1);
    tick();
    chk("t3_req", 1, 0, 3, 0, 1);
    io.iu_yy_xx_dbgon = 1'b1;
    tick();
    chk("t3_dbg", 0, 0, 3, 0, 2);
    do_exit("t3", 3, 2);

    // Request timeout: req high for exactly 5 cycles.
    io.regs_ctrl_halt_req = 1'b1;
    tick();
    io.regs_ctrl_halt_req = 1'b0;
    chk("t4_req1", 1, 0, 1, 0, 2);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk($sformatf("t4_req%0d", i), 1, 0, 1, 0, 2);
    end
    tick();
    chk("t4_timeout", 0, 0, 1, 1, 2);
    tick();
    chk("t4_idle", 0, 0, 1, 1, 2);
    io.regs_ctrl_cause_clr = 1'b1;
    tick();
    io.regs_ctrl_cause_clr = 1'b0;
    chk("t4_clr", 0, 0, 0, 0, 0);

    // Single step re-entry after exit.
    io.regs_ctrl_step_en = 1'b1;
    io.iu_yy_xx_dbgon = 1'b1;
    tick();
    chk("t5_dbg_ext", 0, 0, 0, 0, 0);
    io.regs_ctrl_exit_dbg = 1'b1;
    tick();
    io.regs_ctrl_exit_dbg = 1'b0;
    chk("t5_exit", 0, 1, 0, 0, 0);
    tick();
    chk("t5_exit_hold", 0, 1, 0, 0, 0);
    io.iu_yy_xx_dbgon = 1'b0;
    tick();
    chk("t5_idle", 0, 0, 0, 0, 0);
    tick();
    chk("t5_wait_ret", 0, 0, 0, 0, 0);
    io.iu_had_xx_retire_normal = 1'b1;
    tick();
    io.iu_had_xx_retire_normal = 1'b0;
    chk("t5_step_req", 1, 0, 4, 0, 0);
    io.iu_yy_xx_dbgon = 1'b1;
    tick();
    chk("t5_dbg", 0, 0, 4, 0, 0);
    io.regs_ctrl_step_en = 1'b0;
    do_exit("t5", 4, 0);
    io.iu_had_xx_retire_normal = 1'b1;
    tick();
    io.iu_had_xx_retire_normal = 1'b0;
    chk("t5_no_step", 0, 0, 4, 0, 0);

    // Counter saturation at CNT_W=2.
    io.regs_ctrl_cause_clr = 1'b1;
    tick();
    io.regs_ctrl_cause_clr = 1'b0;
    chk("t6_clr", 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      int pv;
      int nv;
      pv = (i - 1 > 3) ? 3 : i - 1;
      nv = (i > 3) ? 3 : i;
      io.bkpt_ctrl_req = 1'b1;
      tick();
      io.bkpt_ctrl_req = 1'b0;
      chk($sformatf("t6_req%0d", i), 1, 0, 2, 0, 2'(pv));
      io.iu_yy_xx_dbgon = 1'b1;
      tick();
      chk($sformatf("t6_dbg%0d", i), 0, 0, 2, 0, 2'(nv));
      do_exit($sformatf("t6_%0d", i), 2, 2'(nv));
    end

    // Clear racing an increment: counter lands on 1, cause cleared.
    io.bkpt_ctrl_req = 1'b1;
    tick();
    io.bkpt_ctrl_req = 1'b0;
    chk("t7_req", 1, 0, 2, 0, 3);
    io.iu_yy_xx_dbgon = 1'b1;
    io.regs_ctrl_cause_clr = 1'b1;
    tick();
    io.regs_ctrl_cause_clr = 1'b0;
    chk("t7_clr_inc", 0, 0, 0, 0, 1);
    do_exit("t7", 0, 1);

    // Clear racing a capture: cause kept, counter cleared.
    io.bkpt_ctrl_req = 1'b1;
    io.regs_ctrl_cause_clr = 1'b1;
    tick();
    io.bkpt_ctrl_req = 1'b0;
    io.regs_ctrl_cause_clr = 1'b0;
    chk("t8_clr_cap", 1, 0, 2, 0, 0);

    // Reset in REQ drops the request.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t8_rst", 0, 0, 0, 0, 0);
    tick();
    chk("t8_post_rst", 0, 0, 0, 0, 0);

    // Data bkpt beats a pending inst bkpt.
    io.bkpt_ctrl_inst_fetch_dbq_req = 1'b1;
    tick();
    io.bkpt_ctrl_inst_fetch_dbq_req = 1'b0;
    chk("t9_pend", 0, 0, 0, 0, 0);
    io.bkpt_ctrl_req = 1'b1;
    tick();
    io.bkpt_ctrl_req = 1'b0;
    chk("t9_req", 1, 0, 2, 0, 0);
    io.iu_yy_xx_dbgon = 1'b1;
    tick();
    chk("t9_dbg", 0, 0, 2, 0, 1);
    do_exit("t9", 2, 1);
    tick();
    chk("t9_no_pend", 0, 0, 2, 0, 1);

    tick();
    tick();
    if (sb_q.size() != 0) begin
      n_err += sb_q.size();
      $display("FAIL scoreboard_drain: got %0d pending, want 0",
               sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
